// File: rtl/rmst_fm_tile_loader.sv
// rmst_fm_tile_loader
//   Read-master controller that fetches one input feature-map tile from
//   external memory as a sequence of bursts. The tile extent follows from the
//   kernel size and stride, is clipped at the feature-map edges, and each row
//   is split into bursts of at most MAX_BURST words.
//
// Ports
//   clk                    clock
//   rst                    asynchronous reset, active-low
//   load_start             tile load request (level, sampled in IDLE only)
//   load_done              one-cycle pulse when the whole tile has been moved
//   fm_base                word base address of the feature map
//   tile_base_n/row/col    tile origin: channel, input row, input column
//   param_raddr            burst byte address (registered, held between bursts)
//   param_iolen            burst length in words (registered, held between bursts)
//   load_trans_start       one-cycle pulse, param_* valid
//   load_trans_done        one-cycle pulse from the read master, burst finished
//   load_fifo_almost_full  throttle, no new burst is configured while high
//
// state  | meaning
// IDLE   | waiting for load_start, inputs latched on request
// CALC   | clip tile extent against the feature-map edges
// WAIT   | burst pending, held off by almost_full
// CONFIG | compute and register burst address/length
// TRANS  | burst outstanding, waiting for load_trans_done
// NEXT   | advance col-offset / row / channel counters
// DONE   | load_done pulse

module rmst_fm_tile_loader #(
    parameter int CW        = 16,
    parameter int XAW       = 32,
    parameter int DW        = 32,
    parameter int N         = 32,
    parameter int R         = 64,
    parameter int C         = 32,
    parameter int K         = 3,
    parameter int S         = 1,
    parameter int Tn        = 16,
    parameter int Tr        = 16,
    parameter int Tc        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    output logic           load_done,
    input  logic [XAW-1:0] fm_base,
    input  logic [CW-1:0]  tile_base_n,
    input  logic [CW-1:0]  tile_base_row,
    input  logic [CW-1:0]  tile_base_col,
    output logic [XAW-1:0] param_raddr,
    output logic [CW-1:0]  param_iolen,
    output logic           load_trans_start,
    input  logic           load_trans_done,
    input  logic           load_fifo_almost_full
);

    localparam int ROWS  = (Tr - 1) * S + K;
    localparam int COLS  = (Tc - 1) * S + K;
    localparam int BYTES = DW / 8;

    typedef enum logic [2:0] {IDLE, CALC, WAIT, CONFIG, TRANS, NEXT, DONE} state_t;

    state_t         r_state;
    logic [XAW-1:0] r_fm_base;
    logic [CW-1:0]  r_base_n, r_base_row, r_base_col;
    logic [CW-1:0]  r_nn, r_rr, r_cc;
    logic [CW-1:0]  r_n, r_r, r_coff;

    // Extent remaining from the origin to the edge, capped at the tile extent.
    function automatic logic [CW-1:0] clip(input logic [CW-1:0] base, input int dim, input int ext);
        int rem;
        if (int'(base) >= dim) return '0;
        rem = dim - int'(base);
        return (rem < ext) ? CW'(rem) : CW'(ext);
    endfunction

    logic [CW-1:0]  w_nn, w_rr, w_cc;
    logic [CW-1:0]  w_rem, w_len;
    logic [XAW-1:0] w_ch, w_row, w_word;
    logic           w_last_col, w_last_row, w_last_ch;

    assign w_nn = clip(r_base_n,   N, Tn);
    assign w_rr = clip(r_base_row, R, ROWS);
    assign w_cc = clip(r_base_col, C, COLS);

    assign w_ch   = XAW'(r_base_n) + XAW'(r_n);
    assign w_row  = XAW'(r_base_row) + XAW'(r_r);
    assign w_word = r_fm_base + w_ch * XAW'(R * C) + w_row * XAW'(C)
                    + XAW'(r_base_col) + XAW'(r_coff);

    assign w_rem = r_cc - r_coff;
    assign w_len = (w_rem > CW'(MAX_BURST)) ? CW'(MAX_BURST) : w_rem;

    assign w_last_col = (r_coff + CW'(MAX_BURST)) >= r_cc;
    assign w_last_row = r_r == (r_rr - 1'b1);
    assign w_last_ch  = r_n == (r_nn - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_fm_base        <= '0;
            r_base_n         <= '0;
            r_base_row       <= '0;
            r_base_col       <= '0;
            r_nn             <= '0;
            r_rr             <= '0;
            r_cc             <= '0;
            r_n              <= '0;
            r_r              <= '0;
            r_coff           <= '0;
            param_raddr      <= '0;
            param_iolen      <= '0;
            load_trans_start <= 1'b0;
            load_done        <= 1'b0;
        end else begin
            load_trans_start <= 1'b0;
            load_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_fm_base  <= fm_base;
                        r_base_n   <= tile_base_n;
                        r_base_row <= tile_base_row;
                        r_base_col <= tile_base_col;
                        r_n        <= '0;
                        r_r        <= '0;
                        r_coff     <= '0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_nn <= w_nn;
                    r_rr <= w_rr;
                    r_cc <= w_cc;
                    if (w_nn == '0 || w_rr == '0 || w_cc == '0) begin
                        load_done <= 1'b1;
                        r_state   <= DONE;
                    end else if (load_fifo_almost_full) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= CONFIG;
                    end
                end
                WAIT: begin
                    if (!load_fifo_almost_full) r_state <= CONFIG;
                end
                CONFIG: begin
                    param_raddr      <= w_word * XAW'(BYTES);
                    param_iolen      <= w_len;
                    load_trans_start <= 1'b1;
                    r_state          <= TRANS;
                end
                TRANS: begin
                    if (load_trans_done) r_state <= NEXT;
                end
                NEXT: begin
                    if (w_last_col) begin
                        r_coff <= '0;
                        if (w_last_row) begin
                            r_r <= '0;
                            r_n <= w_last_ch ? '0 : r_n + 1'b1;
                        end else begin
                            r_r <= r_r + 1'b1;
                        end
                    end else begin
                        r_coff <= r_coff + CW'(MAX_BURST);
                    end
                    if (w_last_col && w_last_row && w_last_ch) begin
                        load_done <= 1'b1;
                        r_state   <= DONE;
                    end else if (load_fifo_almost_full) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= CONFIG;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmst_fm_tile_loader.sv
module tb_rmst_fm_tile_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_done;
    logic [31:0] fm_base;
    logic [15:0] tile_base_n, tile_base_row, tile_base_col;
    logic [31:0] param_raddr;
    logic [15:0] param_iolen;
    logic        load_trans_start;
    logic        load_trans_done;
    logic        load_fifo_almost_full;

    int n_checks = 0;
    int n_errors = 0;

    rmst_fm_tile_loader #(
        .CW(16), .XAW(32), .DW(32), .N(4), .R(8), .C(8), .K(3), .S(1),
        .Tn(2), .Tr(4), .Tc(4), .MAX_BURST(4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_start            (load_start),
        .load_done             (load_done),
        .fm_base               (fm_base),
        .tile_base_n           (tile_base_n),
        .tile_base_row         (tile_base_row),
        .tile_base_col         (tile_base_col),
        .param_raddr           (param_raddr),
        .param_iolen           (param_iolen),
        .load_trans_start      (load_trans_start),
        .load_trans_done       (load_trans_done),
        .load_fifo_almost_full (load_fifo_almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count negedges until a trans_start or load_done is seen; request
    // strobes are released after the first edge.
    task automatic wait_event(output int cyc, output bit got_ts, output bit got_done);
        cyc = 0; got_ts = 0; got_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load_start      = 1'b0;
            load_trans_done = 1'b0;
            cyc++;
            if (load_trans_start) begin got_ts = 1; return; end
            if (load_done)        begin got_done = 1; return; end
        end
        chk("timeout", 1, 0);
    endtask

    // mode: 0 normal, 1 almost_full at start, 2 reset during burst 5,
    //       3 spurious trans_done in WAIT / load_start during TRANS
    task automatic run_tile(input int bn, input int br, input int bc,
                            input int nn, input int rr, input int cc,
                            input longint first_raddr, input int mode);
        int cyc, bursts;
        bit got_ts, got_done, last;
        longint exp_a, exp_l;
        tile_base_n   = 16'(bn);
        tile_base_row = 16'(br);
        tile_base_col = 16'(bc);
        load_start    = 1'b1;
        if (mode == 1) begin
            load_fifo_almost_full = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                load_start = 1'b0;
                chk("af_hold_no_start", load_trans_start, 0);
            end
            load_fifo_almost_full = 1'b0;
            wait_event(cyc, got_ts, got_done);
            chk("af_release_latency", cyc, 2);
        end else begin
            wait_event(cyc, got_ts, got_done);
            if (nn * rr * cc == 0) begin
                chk("empty_done", got_done, 1);
                chk("empty_done_latency", cyc, 2);
                chk("empty_no_start", got_ts, 0);
            end else begin
                chk("first_latency", cyc, 3);
            end
        end
        bursts = 0;
        for (int n = 0; n < nn; n++)
            for (int r = 0; r < rr; r++)
                for (int coff = 0; coff < cc; coff += 4) begin
                    exp_a = (65536 + (bn + n) * 64 + (br + r) * 8 + bc + coff) * 4;
                    exp_l = (cc - coff > 4) ? 4 : cc - coff;
                    last  = (n == nn - 1) && (r == rr - 1) && (coff + 4 >= cc);
                    chk("ts_seen", got_ts, 1);
                    chk("raddr", param_raddr, exp_a);
                    chk("iolen", param_iolen, exp_l);
                    bursts++;
                    if (bursts == 1) chk("first_raddr", param_raddr, first_raddr);
                    @(negedge clk);
                    chk("ts_pulse", load_trans_start, 0);
                    if (mode == 2 && bursts == 5) begin
                        rst = 1'b0;
                        @(negedge clk);
                        chk("rst_raddr", param_raddr, 0);
                        chk("rst_iolen", param_iolen, 0);
                        chk("rst_ts", load_trans_start, 0);
                        chk("rst_done", load_done, 0);
                        rst = 1'b1;
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            chk("post_rst_quiet", load_done | load_trans_start, 0);
                        end
                        return;
                    end
                    if (mode == 3 && bursts == 2) begin
                        load_start = 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            @(negedge clk);
                            chk("busy_load_start", load_trans_start, 0);
                        end
                        load_start            = 1'b0;
                        load_fifo_almost_full = 1'b1;
                        load_trans_done       = 1'b1;
                        @(negedge clk);
                        load_trans_done = 1'b0;
                        @(negedge clk);
                        load_trans_done = 1'b1;
                        @(negedge clk);
                        load_trans_done = 1'b0;
                        for (int i = 0; i < 3; i++) begin
                            @(negedge clk);
                            chk("wait_quiet", load_trans_start | load_done, 0);
                        end
                        load_fifo_almost_full = 1'b0;
                        wait_event(cyc, got_ts, got_done);
                        chk("wait_release_latency", cyc, 2);
                    end else begin
                        load_trans_done = 1'b1;
                        wait_event(cyc, got_ts, got_done);
                        if (last) begin
                            chk("done_seen", got_done, 1);
                            chk("done_latency", cyc, 2);
                        end else begin
                            chk("next_latency", cyc, 3);
                        end
                    end
                end
        chk("done_high", load_done, 1);
        @(negedge clk);
        chk("done_pulse", load_done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_quiet", load_trans_start | load_done, 0);
        end
    endtask

    initial begin
        rst                   = 1'b0;
        load_start            = 1'b0;
        load_trans_done       = 1'b0;
        load_fifo_almost_full = 1'b0;
        fm_base               = 32'd65536;
        tile_base_n           = '0;
        tile_base_row         = '0;
        tile_base_col         = '0;
        repeat (3) @(negedge clk);
        chk("reset_raddr", param_raddr, 0);
        chk("reset_iolen", param_iolen, 0);
        chk("reset_ts", load_trans_start, 0);
        chk("reset_done", load_done, 0);
        rst = 1'b1;
        @(negedge clk);

        run_tile(0, 0, 0, 2, 6, 6, 262144, 0);   // T1: 24 bursts, iolen 4,2
        run_tile(2, 4, 4, 2, 4, 4, 262800, 0);   // T2: clipped to 4x4
        run_tile(0, 8, 0, 2, 0, 6, 0,      0);   // T3: origin off the map
        run_tile(0, 0, 0, 2, 6, 6, 262144, 1);   // T4: almost_full at start
        run_tile(0, 0, 0, 2, 6, 6, 262144, 2);   // T5: reset in burst 5
        run_tile(0, 0, 0, 2, 6, 6, 262144, 0);   //     restart from burst 0
        run_tile(2, 4, 4, 2, 4, 4, 262800, 3);   // T6: spurious inputs

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
